// File: rtl/pulse_generator_pkg.sv
// Shared constants and types for pulse_generator and its downstream timing monitor.
// The monitor defaults its expected timings from the generator constants defined here.
package pulse_generator_pkg;

  // Generator timing, in clock cycles.
  localparam int reset_delay_c = 4;
  localparam int start_delay_c = 3;
  localparam int pulse_width_c = 5;

  // Longest time the monitor waits in any state before giving up.
  localparam int mon_timeout_c = 1024;

  typedef enum logic [2:0] {
    WAIT_READY,
    ARMED,
    WAIT_PULSE,
    PULSE_HIGH,
    REPORT
  } mon_state_t;

  typedef struct packed {
    logic overlap;
    logic timeout;
    logic width;
    logic delay;
  } meas_err_t;

endpackage

// File: rtl/pulse_mon_counter.sv
// Saturating up-counter. Clear and enable together load 1, so the count can
// restart with the current cycle already included.
module pulse_mon_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] base;

  always_comb begin
    base = clear ? '0 : count;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || enable) begin
      if (enable && (base != '1)) begin
        count <= base + CNT_W'(1);
      end else begin
        count <= base;
      end
    end
  end

endmodule

// File: rtl/pulse_timing_monitor.sv
// Measures the ready latency, start-to-pulse delay and pulse width of pulse_generator
// and checks each of them against the expected constants.
module pulse_timing_monitor
  import pulse_generator_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int EXP_READY = reset_delay_c,
  parameter int EXP_DELAY = start_delay_c,
  parameter int EXP_WIDTH = pulse_width_c,
  parameter int TIMEOUT_C = mon_timeout_c
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             pulse_out,
  input  logic             pulse_generator_ready,
  output logic [CNT_W-1:0] ready_time,
  output logic             ready_time_valid,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_delay,
  output logic [CNT_W-1:0] meas_width,
  output logic [3:0]       meas_err,
  output logic             any_err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam logic [CNT_W-1:0] exp_ready_v = CNT_W'(EXP_READY);
  localparam logic [CNT_W-1:0] exp_delay_v = CNT_W'(EXP_DELAY);
  localparam logic [CNT_W-1:0] exp_width_v = CNT_W'(EXP_WIDTH);
  localparam logic [CNT_W-1:0] timeout_v   = CNT_W'(TIMEOUT_C);

  mon_state_t       state;
  logic             start_q;
  logic             pulse_q;
  logic             ready_q;
  logic             overlap_f;
  logic             timeout_f;

  logic             start_rise;
  logic             pulse_rise;
  logic             pulse_fall;
  logic             ready_rise;
  logic             ready_fall;
  logic             abort;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_clr;
  logic             cnt_en;
  logic             pass_en;
  logic             fail_en;
  meas_err_t        err_now;

  assign start_rise = start & ~start_q;
  assign pulse_rise = pulse_out & ~pulse_q;
  assign pulse_fall = ~pulse_out & pulse_q;
  assign ready_rise = pulse_generator_ready & ~ready_q;
  assign ready_fall = ~pulse_generator_ready & ready_q;
  assign abort      = ready_fall && (state != WAIT_READY);

  // Value the counter takes this cycle if incremented; captures use it so the
  // sampling cycle itself is included in the measurement.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    err_now         = '0;
    err_now.overlap = overlap_f;
    err_now.timeout = timeout_f;
    err_now.width   = (meas_width != exp_width_v);
    err_now.delay   = (meas_delay != exp_delay_v);
  end

  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (abort) begin
      cnt_clr = 1'b1;
    end else begin
      unique case (state)
        WAIT_READY: cnt_en = 1'b1;
        ARMED:      cnt_clr = start_rise;
        WAIT_PULSE: begin
          cnt_clr = pulse_rise;
          cnt_en  = 1'b1;
        end
        PULSE_HIGH: cnt_en = pulse_out;
        REPORT:     cnt_en = 1'b0;
        default:    cnt_clr = 1'b1;
      endcase
    end
  end

  assign pass_en = (state == REPORT) && !abort && !(|err_now);
  assign fail_en = (state == REPORT) && !abort && (|err_now);

  pulse_mon_counter #(.CNT_W(CNT_W)) u_meas_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clr),
    .enable  (cnt_en),
    .count   (cnt)
  );

  pulse_mon_counter #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .enable  (pass_en),
    .count   (pass_cnt)
  );

  pulse_mon_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (1'b0),
    .enable  (fail_en),
    .count   (fail_cnt)
  );

  // A ready drop outranks everything, including a pending REPORT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= WAIT_READY;
      start_q          <= 1'b0;
      pulse_q          <= 1'b0;
      ready_q          <= 1'b0;
      overlap_f        <= 1'b0;
      timeout_f        <= 1'b0;
      ready_time       <= '0;
      ready_time_valid <= 1'b0;
      meas_valid       <= 1'b0;
      meas_delay       <= '0;
      meas_width       <= '0;
      meas_err         <= '0;
      any_err          <= 1'b0;
    end else begin
      start_q    <= start;
      pulse_q    <= pulse_out;
      ready_q    <= pulse_generator_ready;
      meas_valid <= 1'b0;
      if (abort) begin
        state            <= WAIT_READY;
        ready_time_valid <= 1'b0;
        overlap_f        <= 1'b0;
        timeout_f        <= 1'b0;
      end else begin
        unique case (state)
          WAIT_READY: begin
            if (ready_rise) begin
              ready_time       <= cnt_inc;
              ready_time_valid <= 1'b1;
              if (cnt_inc != exp_ready_v) any_err <= 1'b1;
              state <= ARMED;
            end else if (cnt_inc >= timeout_v) begin
              ready_time <= timeout_v;
              any_err    <= 1'b1;
              state      <= ARMED;
            end
          end
          ARMED: begin
            if (start_rise) begin
              overlap_f <= 1'b0;
              timeout_f <= 1'b0;
              state     <= WAIT_PULSE;
            end
          end
          WAIT_PULSE: begin
            if (start_rise) overlap_f <= 1'b1;
            if (pulse_rise) begin
              meas_delay <= cnt_inc;
              state      <= PULSE_HIGH;
            end else if (cnt_inc >= timeout_v) begin
              meas_delay <= timeout_v;
              meas_width <= timeout_v;
              timeout_f  <= 1'b1;
              state      <= REPORT;
            end
          end
          PULSE_HIGH: begin
            if (start_rise) overlap_f <= 1'b1;
            if (pulse_fall) begin
              meas_width <= cnt;
              state      <= REPORT;
            end else if (cnt_inc >= timeout_v) begin
              meas_width <= timeout_v;
              timeout_f  <= 1'b1;
              state      <= REPORT;
            end
          end
          REPORT: begin
            meas_valid <= 1'b1;
            meas_err   <= err_now;
            if (|err_now) any_err <= 1'b1;
            state <= ARMED;
          end
          default: state <= WAIT_READY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_timing_monitor.sv
// Self-checking bench for pulse_timing_monitor: directed vector table, hand-written
// abort/reset sequences and randomized pulses checked against a transaction-level model.
module tb_pulse_timing_monitor;

  localparam int CNT_W = 16;
  localparam int EXP_R = 4;
  localparam int EXP_D = 3;
  localparam int EXP_W = 5;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             pulse_out = 1'b0;
  logic             pulse_generator_ready = 1'b0;
  logic [CNT_W-1:0] ready_time;
  logic             ready_time_valid;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_delay;
  logic [CNT_W-1:0] meas_width;
  logic [3:0]       meas_err;
  logic             any_err;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int m_pass   = 0;
  int m_fail   = 0;
  int m_any    = 0;

  typedef struct {
    int d;
    int w;
    bit np;
    int ovl;
    int e_idx;
    int e_dly;
    int e_wid;
    int e_err;
  } vec_t;

  vec_t vecs[8];

  pulse_timing_monitor #(
    .CNT_W(CNT_W), .EXP_READY(EXP_R), .EXP_DELAY(EXP_D), .EXP_WIDTH(EXP_W), .TIMEOUT_C(TMO)
  ) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .start                 (start),
    .pulse_out             (pulse_out),
    .pulse_generator_ready (pulse_generator_ready),
    .ready_time            (ready_time),
    .ready_time_valid      (ready_time_valid),
    .meas_valid            (meas_valid),
    .meas_delay            (meas_delay),
    .meas_width            (meas_width),
    .meas_err              (meas_err),
    .any_err               (any_err),
    .pass_cnt              (pass_cnt),
    .fail_cnt              (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level expectation: where the result appears (in cycles after the
  // start edge) and what it reports, from the delay/width/timeout rules.
  task automatic model(input int d, input int w, input bit np, input int ovl,
                       output int idx, output int dly, output int wid, output int err);
    bit to;
    to = 1'b0;
    if (np || d >= TMO) begin
      dly = TMO; wid = TMO; to = 1'b1; idx = TMO + 1;
    end else if (w >= TMO) begin
      dly = d; wid = TMO; to = 1'b1; idx = d + TMO;
    end else begin
      dly = d; wid = w; idx = d + w + 1;
    end
    err = 0;
    if (ovl >= 1 && ovl < idx) err += 8;
    if (to) err += 4;
    if (wid != EXP_W) err += 2;
    if (dly != EXP_D) err += 1;
  endtask

  task automatic applyStimulus(input int d, input int w, input bit np, input int ovl,
                               input int limit, output int idx, output int dly,
                               output int wid, output int err);
    idx = -1; dly = 0; wid = 0; err = 0;
    for (int i = 0; i < limit; i++) begin
      start     = (i == 0) || (i == ovl);
      pulse_out = !np && (i >= d) && (i < d + w);
      step();
      if (meas_valid) begin
        idx = i;
        dly = int'(meas_delay);
        wid = int'(meas_width);
        err = int'(meas_err);
        break;
      end
    end
    start     = 1'b0;
    pulse_out = 1'b0;
  endtask

  task automatic runCase(input string tag, input int d, input int w, input bit np,
                         input int ovl, input int e_idx, input int e_dly,
                         input int e_wid, input int e_err);
    int idx, dly, wid, err;
    applyStimulus(d, w, np, ovl, e_idx + 6, idx, dly, wid, err);
    if (e_err == 0) m_pass++; else m_fail++;
    if (e_err != 0) m_any = 1;
    checkOutput({tag, " valid_cycle"}, idx, e_idx);
    checkOutput({tag, " meas_delay"}, dly, e_dly);
    checkOutput({tag, " meas_width"}, wid, e_wid);
    checkOutput({tag, " meas_err"}, err, e_err);
    checkOutput({tag, " pass_cnt"}, int'(pass_cnt), m_pass);
    checkOutput({tag, " fail_cnt"}, int'(fail_cnt), m_fail);
    checkOutput({tag, " any_err"}, int'(any_err), m_any);
    step();
    checkOutput({tag, " valid_strobe_len"}, int'(meas_valid), 0);
    step();
  endtask

  initial begin
    int r_idx, r_dly, r_wid, r_err, d, w, ovl;
    bit np;
    bit seen;

    vecs[0] = '{d: 3, w: 5,  np: 0, ovl: -1, e_idx: 9,  e_dly: 3,  e_wid: 5,  e_err: 0};
    vecs[1] = '{d: 3, w: 6,  np: 0, ovl: -1, e_idx: 10, e_dly: 3,  e_wid: 6,  e_err: 2};
    vecs[2] = '{d: 3, w: 5,  np: 1, ovl: -1, e_idx: 17, e_dly: 16, e_wid: 16, e_err: 7};
    vecs[3] = '{d: 3, w: 5,  np: 0, ovl: 5,  e_idx: 9,  e_dly: 3,  e_wid: 5,  e_err: 8};
    vecs[4] = '{d: 1, w: 1,  np: 0, ovl: -1, e_idx: 3,  e_dly: 1,  e_wid: 1,  e_err: 3};
    vecs[5] = '{d: 2, w: 16, np: 0, ovl: -1, e_idx: 18, e_dly: 2,  e_wid: 16, e_err: 7};
    vecs[6] = '{d: 3, w: 15, np: 0, ovl: -1, e_idx: 19, e_dly: 3,  e_wid: 15, e_err: 2};
    vecs[7] = '{d: 14, w: 5, np: 0, ovl: -1, e_idx: 20, e_dly: 14, e_wid: 5,  e_err: 1};

    #12;
    checkOutput("reset ready_time_valid", int'(ready_time_valid), 0);
    checkOutput("reset outputs_or", int'(|{ready_time, meas_valid, meas_delay, meas_width,
                                          meas_err, any_err, pass_cnt, fail_cnt}), 0);

    // Generator ready sampled on the 4th clock after reset release.
    step();
    reset_n = 1'b1;
    step(); step(); step();
    pulse_generator_ready = 1'b1;
    step();
    checkOutput("ready ready_time", int'(ready_time), EXP_R);
    checkOutput("ready ready_time_valid", int'(ready_time_valid), 1);
    checkOutput("ready any_err", int'(any_err), 0);
    step();

    for (int k = 0; k < 8; k++) begin
      runCase($sformatf("vec%0d", k), vecs[k].d, vecs[k].w, vecs[k].np, vecs[k].ovl,
              vecs[k].e_idx, vecs[k].e_dly, vecs[k].e_wid, vecs[k].e_err);
    end

    // Ready dropped mid-pulse: no result, then re-measured from the drop.
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      start     = (i == 0);
      pulse_out = (i >= 3) && (i < 8);
      pulse_generator_ready = !(i >= 5 && i < 9);
      step();
      if (meas_valid) seen = 1'b1;
      if (i == 5) checkOutput("abort ready_time_valid", int'(ready_time_valid), 0);
    end
    start = 1'b0; pulse_out = 1'b0;
    checkOutput("abort no_meas_valid", int'(seen), 0);
    checkOutput("abort ready_time", int'(ready_time), EXP_R);
    checkOutput("abort ready_time_valid_again", int'(ready_time_valid), 1);
    checkOutput("abort pass_cnt_kept", int'(pass_cnt), m_pass);
    checkOutput("abort fail_cnt_kept", int'(fail_cnt), m_fail);
    step();

    for (int k = 0; k < 40; k++) begin
      np  = ($urandom_range(0, 7) == 0);
      d   = $urandom_range(1, 12);
      w   = $urandom_range(1, 18);
      ovl = -1;
      model(d, w, np, -1, r_idx, r_dly, r_wid, r_err);
      if ($urandom_range(0, 3) == 0) ovl = $urandom_range(2, r_idx - 1);
      model(d, w, np, ovl, r_idx, r_dly, r_wid, r_err);
      runCase($sformatf("rnd%0d", k), d, w, np, ovl, r_idx, r_dly, r_wid, r_err);
    end

    // Reset asserted while the pulse is high clears everything at once.
    for (int i = 0; i < 6; i++) begin
      start     = (i == 0);
      pulse_out = (i >= 3);
      step();
    end
    reset_n = 1'b0;
    #1;
    checkOutput("midreset pass_cnt", int'(pass_cnt), 0);
    checkOutput("midreset fail_cnt", int'(fail_cnt), 0);
    checkOutput("midreset any_err", int'(any_err), 0);
    checkOutput("midreset ready_time_valid", int'(ready_time_valid), 0);
    checkOutput("midreset ready_time", int'(ready_time), 0);
    checkOutput("midreset meas_delay", int'(meas_delay), 0);
    checkOutput("midreset meas_width", int'(meas_width), 0);
    checkOutput("midreset meas_err", int'(meas_err), 0);
    start = 1'b0; pulse_out = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_timing_monitor.md
# pulse_timing_monitor

Synthesizable monitor placed directly downstream of `pulse_generator`, on the same clock. It consumes `start`, `pulse_out` and `pulse_generator_ready_after_reset`, and measures three cycle counts: reset-release-to-ready, start-to-pulse delay, and pulse width. Each count is compared against the expected constants, and per-pulse results, sticky error and pass/fail tallies are reported. This gives in-system and post-synthesis checking of the same timing the bench checks.

## Interface
Parameters:
- `CNT_W`, 16, width of all measurement counters and tallies.
- `EXP_READY`, `reset_delay_c`, expected cycles from reset release to ready.
- `EXP_DELAY`, `start_delay_c`, expected cycles from start rise to pulse rise.
- `EXP_WIDTH`, `pulse_width_c`, expected cycles `pulse_out` is high.
- `TIMEOUT_C`, 1024, maximum cycles spent waiting in any state.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous active-low reset.
- `start` in 1: start strobe, same signal driven into `pulse_generator`.
- `pulse_out` in 1: generator output.
- `pulse_generator_ready` in 1: generator ready-after-reset.
- `ready_time` out CNT_W: measured reset-to-ready cycles.
- `ready_time_valid` out 1: held high once `ready_time` has been captured.
- `meas_valid` out 1: one-cycle strobe marking a per-pulse result.
- `meas_delay` out CNT_W: captured start-to-pulse cycles.
- `meas_width` out CNT_W: captured pulse-high cycles.
- `meas_err` out 4: {overlap, timeout, width, delay}, valid with `meas_valid`.
- `any_err` out 1: sticky OR of all errors, including ready mismatch.
- `pass_cnt` out CNT_W: saturating count of passing pulses.
- `fail_cnt` out CNT_W: saturating count of failing pulses.

## Operation
- All inputs are synchronous to `clk`. `start_q` and `pulse_q` registers provide rise/fall detection, where rise = x & ~x_q.
- States:
  - WAIT_READY: counter increments every cycle from the first clock after `reset_n` deasserts. On a `pulse_generator_ready` rise it captures `ready_time`, sets `ready_time_valid`, sets `any_err` if the count ≠ EXP_READY, then goes to ARMED. If the count reaches TIMEOUT_C it sets `any_err` and goes to ARMED with `ready_time` = TIMEOUT_C.
  - ARMED: on a `start` rise, clear the counter to 0 and go to WAIT_PULSE.
  - WAIT_PULSE: counter increments. On a `pulse_out` rise, capture `meas_delay` and go to PULSE_HIGH with the counter at 1. A `start` rise here sets the overlap flag. Reaching TIMEOUT_C sets timeout and goes to REPORT.
  - PULSE_HIGH: counter increments while `pulse_out` is sampled high. On a `pulse_out` fall, capture `meas_width` and go to REPORT. A `start` rise sets overlap. TIMEOUT_C sets timeout and goes to REPORT.
  - REPORT: for one cycle, assert `meas_valid`, drive `meas_err`, increment `pass_cnt` if `meas_err`==0 else `fail_cnt`, OR `meas_err` into `any_err`, then go to ARMED.
- The delay error bit is set when `meas_delay` ≠ EXP_DELAY. The width error bit is set when `meas_width` ≠ EXP_WIDTH. On timeout, the un-captured fields read TIMEOUT_C.
- Counters saturate at 2^CNT_W−1. Tallies saturate and never wrap.
- If `pulse_generator_ready` falls in any state other than WAIT_READY, abort without `meas_valid`, clear the counter, and go to WAIT_READY. `ready_time_valid` clears; tallies and `any_err` are kept.
- Simultaneous `start` rise and `pulse_out` rise in ARMED: the start is taken, and the pulse edge is ignored for that cycle.

## Timing
- Reset values: every output 0, state WAIT_READY.
- Delay: if `start` rises at sample cycle N and `pulse_out` rises at cycle N+D, then `meas_delay` = D.
- Width: `meas_width` = number of cycles `pulse_out` is sampled high.
- `meas_valid` rises exactly one cycle after the cycle in which the `pulse_out` fall is sampled. All result outputs are registered.
- `reset_n` assertion clears everything immediately, including mid-measurement.
- Back-to-back pulses: a `start` rise in the REPORT cycle is ignored. The earliest accepted `start` is the cycle after REPORT.

## Structure
- Add to `pulse_generator_pkg`:
  - `mon_state_t` enum (WAIT_READY, ARMED, WAIT_PULSE, PULSE_HIGH, REPORT).
  - `meas_err_t` packed struct {overlap, timeout, width, delay}.
  - `mon_timeout_c` = 1024.
- One sub-module, `pulse_mon_counter`: a saturating CNT_W counter with clear/enable, used for the measurement counter and both tallies.

## Test plan
- EXP_READY=4, EXP_DELAY=3, EXP_WIDTH=5. Generator ready 4 cycles after reset release, start → `pulse_out` after 3 cycles, high 5 cycles → `ready_time`=4, `meas_delay`=3, `meas_width`=5, `meas_err`=0, `pass_cnt`=1, `any_err`=0.
- Same setup, pulse width forced to 6 → `meas_width`=6, `meas_err`=0001b<<1 (width), `fail_cnt`=1, `any_err`=1.
- `start` with no `pulse_out`, TIMEOUT_C=16 → `meas_valid` 17 cycles after the start edge is sampled, timeout set, `meas_delay`=16.
- Second `start` rise while `pulse_out` is high → overlap set, width still measured correctly.
- `pulse_generator_ready` dropped mid-pulse → no `meas_valid`, `ready_time_valid`=0, state WAIT_READY; next ready rise re-measured.
- `reset_n` asserted during PULSE_HIGH → all outputs 0 within the same cycle, `pass_cnt`=`fail_cnt`=0.
